// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam logic [1:0] ERR_OK           = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL_SIZE = 2'b11;

    // Byte enables for an access of the given size at the given lane offset.
    function automatic logic [3:0] be_for(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Errors detectable at request time; such requests never touch memory.
    function automatic logic [1:0] req_err(input size_e size, input logic [1:0] addr_lo);
        logic [1:0] err;
        case (size)
            SZ_BYTE: err = ERR_OK;
            SZ_HALF: err = addr_lo[0] ? ERR_MISALIGNED : ERR_OK;
            SZ_WORD: err = (addr_lo != 2'b00) ? ERR_MISALIGNED : ERR_OK;
            default: err = ERR_ILLEGAL_SIZE;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment: store byte enables/replicated data, load extract and sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] shifted;
    logic        sign_fill;

    // Store side: enables and lane-replicated data so any selected lane holds the value.
    always_comb begin
        be_o = be_for(size_i, addr_lo_i);
        case (size_i)
            SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
            SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        sign_fill = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                sign_fill = ~unsigned_i & shifted[7];
                ldata_o   = {{24{sign_fill}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign_fill = ~unsigned_i & shifted[15];
                ldata_o   = {{16{sign_fill}}, shifted[15:0]};
            end
            SZ_WORD: ldata_o = shifted;
            default: ldata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store at a time to a word-addressed RAM with byte enables.
// Latency: error 1, store 2 + grant delay, load 3 + grant delay + read delay (ReqValid to RespValid).
// Backpressure: ReqReady only in IDLE; MemReq held until MemGnt; loads time out after TIMEOUT_CYCLES.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqUnsigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [3:0]            MemBe,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic                  MemGnt,
    input  logic                  MemRValid,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] RespData,
    output logic [1:0]            RespErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    size_e                 size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_err_q, resp_err_d;

    logic [3:0]            be_w;
    logic [DATA_WIDTH-1:0] mem_wdata_w;
    logic [DATA_WIDTH-1:0] load_data_w;
    logic [1:0]            new_err;

    // Alignment always works from the captured request, never the live inputs.
    mem_lane_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (MemRData),
        .be_o       (be_w),
        .wdata_o    (mem_wdata_w),
        .ldata_o    (load_data_w)
    );

    assign new_err = req_err(size_e'(ReqSize), ReqAddr[1:0]);

    // State, timeout counter, captured request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Next-state logic; memory handshakes outside ISSUE/WAIT are deliberately ignored.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d    = ReqWrite;
                    size_d     = size_e'(ReqSize);
                    unsigned_d = ReqUnsigned;
                    addr_d     = ReqAddr;
                    wdata_d    = ReqWData;
                    if (new_err != ERR_OK) begin
                        resp_data_d = '0;
                        resp_err_d  = new_err;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (MemGnt) begin
                    cnt_d = '0;
                    if (write_q) begin
                        resp_data_d = '0;
                        resp_err_d  = ERR_OK;
                        state_d     = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Read data on the final allowed cycle still wins over the timeout.
                if (MemRValid) begin
                    resp_data_d = load_data_w;
                    resp_err_d  = ERR_OK;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = ERR_TIMEOUT;
                    state_d     = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: memory port driven only in ISSUE, response only in RESP.
    always_comb begin
        ReqReady  = (state_q == IDLE);
        MemReq    = 1'b0;
        MemWe     = 1'b0;
        MemAddr   = '0;
        MemBe     = 4'b0000;
        MemWData  = '0;
        RespValid = 1'b0;
        RespData  = '0;
        RespErr   = ERR_OK;
        if (state_q == ISSUE) begin
            MemReq   = 1'b1;
            MemWe    = write_q;
            MemAddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            MemBe    = be_w;
            MemWData = mem_wdata_w;
        end
        if (state_q == RESP) begin
            RespValid = 1'b1;
            RespData  = resp_data_q;
            RespErr   = resp_err_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests, scoreboarded responses.
// Latency: checked per response against the cycle the request was issued.
// Backpressure: waits on ReqReady with a bounded cycle budget.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqUnsigned = 1'b0;
    logic [31:0] ReqAddr = 32'h0;
    logic [31:0] ReqWData = 32'h0;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWData;
    logic        MemGnt = 1'b0;
    logic        MemRValid = 1'b0;
    logic [31:0] MemRData = 32'h0;
    logic        RespValid;
    logic [31:0] RespData;
    logic [1:0]  RespErr;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqSize    (ReqSize),
        .ReqUnsigned(ReqUnsigned),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemBe      (MemBe),
        .MemWData   (MemWData),
        .MemGnt     (MemGnt),
        .MemRValid  (MemRValid),
        .MemRData   (MemRData),
        .RespValid  (RespValid),
        .RespData   (RespData),
        .RespErr    (RespErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && RespValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", RespData, e.data);
                    chk("resp_err", {30'b0, RespErr}, {30'b0, e.err});
                    chk("resp_latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!ReqReady && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("req_ready", {31'b0, ReqReady}, 32'd1);
    endtask

    task automatic check_mem_port(input string tag, input logic wr, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] mwdata);
        chk({tag, "_memreq"}, {31'b0, MemReq}, 32'd1);
        chk({tag, "_memwe"}, {31'b0, MemWe}, {31'b0, wr});
        chk({tag, "_memaddr"}, MemAddr, {addr[31:2], 2'b00});
        chk({tag, "_membe"}, {28'b0, MemBe}, {28'b0, be});
        chk({tag, "_memwdata"}, MemWData, mwdata);
    endtask

    // One full transaction. rv_en=0 means the memory never returns data (timeout).
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input bit rv_en, input int rv_at,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_mwdata, input logic [31:0] exp_data,
                           input logic [1:0] exp_err);
        exp_t e;
        bit   early;
        early = (exp_err == 2'b01) || (exp_err == 2'b11);
        wait_ready();
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
        ReqAddr = addr; ReqWData = wdata;
        e.data = exp_data;
        e.err  = exp_err;
        e.t0   = cyc;
        e.lat  = early ? 1 : (wr ? gnt_dly + 2 : gnt_dly + rv_at + 2);
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs so any use of live request fields shows up.
        ReqValid = 1'b0; ReqAddr = ~addr; ReqWData = ~wdata; ReqSize = ~sz; ReqUnsigned = ~uns;
        if (early) begin
            chk("err_no_memreq", {31'b0, MemReq}, 32'd0);
            @(posedge clk); #1;
            chk("err_no_memreq2", {31'b0, MemReq}, 32'd0);
            return;
        end
        check_mem_port("issue", wr, addr, exp_be, exp_mwdata);
        for (int i = 0; i < gnt_dly; i++) begin
            @(posedge clk); #1;
            check_mem_port("stall", wr, addr, exp_be, exp_mwdata);
        end
        MemGnt = 1'b1;
        @(posedge clk); #1;
        MemGnt = 1'b0;
        chk("post_gnt_memreq", {31'b0, MemReq}, 32'd0);
        if (wr) return;
        if (!rv_en) begin
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1;
            end
            chk("timeout_not_early", {31'b0, RespValid}, 32'd0);
            @(posedge clk); #1;
            chk("timeout_resp_now", {31'b0, RespValid}, 32'd1);
        end else begin
            for (int i = 1; i < rv_at; i++) begin
                @(posedge clk); #1;
            end
            MemRValid = 1'b1; MemRData = rdata;
            @(posedge clk); #1;
            MemRValid = 1'b0; MemRData = 32'h5555_AAAA;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_reqready", {31'b0, ReqReady}, 32'd1);
        chk("rst_memreq", {31'b0, MemReq}, 32'd0);
        chk("rst_respvalid", {31'b0, RespValid}, 32'd0);
        chk("rst_respdata", RespData, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_membe", {28'b0, MemBe}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        //      wr    sz     uns   addr           wdata          gnt rv  at  rdata          be       mwdata         data           err
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,          0, 1,  1, 32'h80FF_FF12, 4'b1000, 32'h0,          32'hFFFF_FF80, 2'b00);
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,          0, 1,  1, 32'hBEEF_1234, 4'b1100, 32'h0,          32'h0000_BEEF, 2'b00);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,          1, 1,  2, 32'hBEEF_1234, 4'b1100, 32'h0,          32'hFFFF_BEEF, 2'b00);
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD,  3, 0,  0, 32'h0,         4'b1100, 32'hABCD_ABCD,  32'h0,         2'b00);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,          0, 0,  0, 32'h0,         4'b0000, 32'h0,          32'h0,         2'b01);
        run_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,          0, 0,  0, 32'h0,         4'b0000, 32'h0,          32'h0,         2'b11);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,          0, 0,  0, 32'h0,         4'b0000, 32'h0,          32'h0,         2'b01);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,          0, 0, 16, 32'h0,         4'b1111, 32'h0,          32'h0,         2'b10);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,          0, 1, 16, 32'hCAFE_F00D, 4'b1111, 32'h0,          32'hCAFE_F00D, 2'b00);
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_565A,  0, 0,  0, 32'h0,         4'b0010, 32'h5A5A_5A5A,  32'h0,         2'b00);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,          0, 1,  3, 32'h0000_9900, 4'b0010, 32'h0,          32'h0000_0099, 2'b00);
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF,  0, 0,  0, 32'h0,         4'b1111, 32'hDEAD_BEEF,  32'h0,         2'b00);
        run_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0,          0, 1,  1, 32'h7F00_0000, 4'b1000, 32'h0,          32'h0000_007F, 2'b00);

        // Reset while a load waits for data: no response, late data ignored.
        wait_ready();
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqUnsigned = 1'b0;
        ReqAddr = 32'h0000_4000; ReqWData = 32'h0;
        @(posedge clk); #1;
        ReqValid = 1'b0; MemGnt = 1'b1;
        @(posedge clk); #1;
        MemGnt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_reqready", {31'b0, ReqReady}, 32'd1);
        chk("midrst_memreq", {31'b0, MemReq}, 32'd0);
        chk("midrst_respvalid", {31'b0, RespValid}, 32'd0);
        chk("midrst_respdata", RespData, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        MemRValid = 1'b1; MemRData = 32'h1111_2222;
        @(posedge clk); #1;
        MemRValid = 1'b0;
        chk("late_rvalid_no_resp", {31'b0, RespValid}, 32'd0);
        chk("late_rvalid_ready", {31'b0, ReqReady}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Normal traffic resumes after the aborted access.
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_5000, 32'h0,          0, 1,  1, 32'h1234_8001, 4'b0011, 32'h0,          32'h0000_8001, 2'b00);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
